l2_tag_lru_engine: RTL and testbench

- Sequential, parametrised tag/state/LRU engine for the L2 cache. Generalises the combinational check/LRU/victim functions.
- Serves one request at a time through a valid/ready handshake.
- Per request: looks up a set, updates true-LRU ordering, selects and installs victims, reports evictions, and applies snoop MESI changes.
- Sits between the L2 controller FSM and the data array. The controller uses the returned way number for data access.

---
 rtl/l2_cache_pkg.sv | 27 ++
 rtl/l2_lru_victim.sv | 47 ++++
 rtl/l2_tag_lru_engine.sv | 214 +++++++++++++++++++++
 tb/tb_l2_tag_lru_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared encodings for the L2 tag/LRU engine: MESI states, request ops, FSM states.
// The line-width helper sizes one stored way: {mesi, lru, tag}.
package l2_cache_pkg;

  localparam logic [1:0] MESI_M = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_S = 2'b10;
  localparam logic [1:0] MESI_I = 2'b11;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_SNOOP  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_RESOLVE,
    ST_RESP
  } state_e;

  function automatic int line_w(input int tag_w, input int way_w);
    return 2 + way_w + tag_w;
  endfunction

endpackage

// File: rtl/l2_lru_victim.sv
// Combinational victim pick and true-LRU touch for one set.
// Victim: lowest invalid way, else the way whose counter is oldest (ASSOC-1).
module l2_lru_victim
  import l2_cache_pkg::*;
#(
  parameter int ASSOC = 8,
  parameter int WAY_W = $clog2(ASSOC)
) (
  input  logic [ASSOC-1:0][WAY_W-1:0] lru_i,
  input  logic [ASSOC-1:0][1:0]       mesi_i,
  input  logic [WAY_W-1:0]            touch_i,
  output logic [WAY_W-1:0]            victim_o,
  output logic [ASSOC-1:0][WAY_W-1:0] lru_o
);

  localparam logic [WAY_W-1:0] LRU_MAX = WAY_W'(ASSOC - 1);

  logic             found;
  logic [WAY_W-1:0] age;

  always_comb begin
    found    = 1'b0;
    victim_o = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!found && mesi_i[w] == MESI_I) begin
        found    = 1'b1;
        victim_o = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (lru_i[w] == LRU_MAX) victim_o = WAY_W'(w);
      end
    end
  end

  // Counters younger than the touched way age by one; the permutation is preserved.
  always_comb begin
    age   = lru_i[touch_i];
    lru_o = lru_i;
    for (int w = 0; w < ASSOC; w++) begin
      if (WAY_W'(w) == touch_i) lru_o[w] = '0;
      else if (lru_i[w] < age)  lru_o[w] = lru_i[w] + 1'b1;
    end
  end

endmodule

// File: rtl/l2_tag_lru_engine.sv
// Sequential tag/state/LRU engine: one request at a time, INIT -> IDLE -> READ -> RESOLVE -> RESP.
// Set storage is in flops; the resolved set is written back in RESOLVE and the response held until resp_ready.
module l2_tag_lru_engine
  import l2_cache_pkg::*;
#(
  parameter int ASSOC   = 8,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 12,
  parameter int WAY_W   = $clog2(ASSOC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [1:0]         req_mesi,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_hit,
  output logic [WAY_W-1:0]   resp_way,
  output logic [1:0]         resp_mesi,
  output logic               resp_evict,
  output logic [TAG_W-1:0]   resp_evict_tag,
  output logic [1:0]         resp_evict_mesi,
  output logic               init_done
);

  localparam int SETS   = 2 ** INDEX_W;
  localparam int LINE_W = line_w(TAG_W, WAY_W);

  typedef struct packed {
    logic [1:0]       mesi;
    logic [WAY_W-1:0] lru;
    logic [TAG_W-1:0] tag;
  } line_t;

  logic [LINE_W-1:0] mem_q [SETS][ASSOC];

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   ptr_q, idx_q;
  logic [1:0]           op_q, mesi_req_q;
  logic [TAG_W-1:0]     tag_req_q;
  line_t [ASSOC-1:0]    set_q, set_d;

  logic                 hit_q, hit_d, evict_q, evict_d;
  logic [WAY_W-1:0]     way_q, way_d;
  logic [1:0]           rmesi_q, rmesi_d, emesi_q, emesi_d;
  logic [TAG_W-1:0]     etag_q, etag_d;

  logic                 hit, lru_upd;
  logic [WAY_W-1:0]     hit_way, victim, touch;
  logic [ASSOC-1:0][WAY_W-1:0] lru_vec, lru_touched;
  logic [ASSOC-1:0][1:0]       mesi_vec;

  always_comb begin
    for (int w = 0; w < ASSOC; w++) begin
      lru_vec[w]  = set_q[w].lru;
      mesi_vec[w] = set_q[w].mesi;
    end
  end

  // Descending scan so the lowest matching way is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (set_q[w].mesi != MESI_I && set_q[w].tag == tag_req_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign touch = hit ? hit_way : victim;

  l2_lru_victim #(.ASSOC(ASSOC), .WAY_W(WAY_W)) u_lru_victim (
    .lru_i    (lru_vec),
    .mesi_i   (mesi_vec),
    .touch_i  (touch),
    .victim_o (victim),
    .lru_o    (lru_touched)
  );

  always_comb begin
    set_d   = set_q;
    lru_upd = 1'b0;
    hit_d   = 1'b0;
    way_d   = '0;
    rmesi_d = MESI_I;
    evict_d = 1'b0;
    etag_d  = '0;
    emesi_d = '0;
    case (op_q)
      OP_LOOKUP: begin
        if (hit) begin
          hit_d   = 1'b1;
          way_d   = hit_way;
          rmesi_d = set_q[hit_way].mesi;
          lru_upd = 1'b1;
        end
      end
      OP_FILL: begin
        if (mesi_req_q != MESI_I) begin
          lru_upd = 1'b1;
          if (hit) begin
            hit_d               = 1'b1;
            way_d               = hit_way;
            rmesi_d             = set_q[hit_way].mesi;
            set_d[hit_way].mesi = mesi_req_q;
          end else begin
            way_d              = victim;
            set_d[victim].tag  = tag_req_q;
            set_d[victim].mesi = mesi_req_q;
            if (set_q[victim].mesi != MESI_I) begin
              evict_d = 1'b1;
              etag_d  = set_q[victim].tag;
              emesi_d = set_q[victim].mesi;
            end
          end
        end
      end
      OP_SNOOP: begin
        if (hit) begin
          hit_d               = 1'b1;
          way_d               = hit_way;
          rmesi_d             = set_q[hit_way].mesi;
          set_d[hit_way].mesi = mesi_req_q;
        end
      end
      default: ;
    endcase
    for (int w = 0; w < ASSOC; w++) begin
      set_d[w].lru = lru_upd ? lru_touched[w] : set_q[w].lru;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      idx_q      <= '0;
      op_q       <= '0;
      tag_req_q  <= '0;
      mesi_req_q <= '0;
      set_q      <= '0;
      hit_q      <= 1'b0;
      way_q      <= '0;
      rmesi_q    <= '0;
      evict_q    <= 1'b0;
      etag_q     <= '0;
      emesi_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) ptr_q <= ptr_q + 1'b1;
      if (state_q == ST_IDLE && req_valid) begin
        idx_q      <= req_index;
        op_q       <= req_op;
        tag_req_q  <= req_tag;
        mesi_req_q <= req_mesi;
      end
      if (state_q == ST_READ) begin
        for (int w = 0; w < ASSOC; w++) set_q[w] <= line_t'(mem_q[idx_q][w]);
      end
      if (state_q == ST_RESOLVE) begin
        hit_q   <= hit_d;
        way_q   <= way_d;
        rmesi_q <= rmesi_d;
        evict_q <= evict_d;
        etag_q  <= etag_d;
        emesi_q <= emesi_d;
      end
    end
  end

  // Array has no reset; INIT sweeps every set after each reset release.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int w = 0; w < ASSOC; w++) mesi_init(w);
    end else if (state_q == ST_RESOLVE) begin
      for (int w = 0; w < ASSOC; w++) mem_q[idx_q][w] <= set_d[w];
    end
  end

  task automatic mesi_init(input int w);
    mem_q[ptr_q][w] <= {MESI_I, WAY_W'(w), {TAG_W{1'b0}}};
  endtask

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    if (ptr_q == {INDEX_W{1'b1}}) state_d = ST_IDLE;
      ST_IDLE:    if (req_valid) state_d = ST_READ;
      ST_READ:    state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_RESP;
      ST_RESP:    if (resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready       = (state_q == ST_IDLE);
    resp_valid      = (state_q == ST_RESP);
    init_done       = (state_q != ST_INIT);
    resp_hit        = hit_q;
    resp_way        = way_q;
    resp_mesi       = rmesi_q;
    resp_evict      = evict_q;
    resp_evict_tag  = etag_q;
    resp_evict_mesi = emesi_q;
  end

endmodule

// File: tb/tb_l2_tag_lru_engine.sv
// Randomized and directed bench for l2_tag_lru_engine against a recency-list cache model.
module tb_l2_tag_lru_engine;
  import l2_cache_pkg::*;

  localparam int ASSOC = 4, INDEX_W = 4, TAG_W = 8, WAY_W = 2, SETS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = '0;
  logic [INDEX_W-1:0] req_index = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [1:0] req_mesi = '0;
  logic resp_valid, resp_ready = 1'b1;
  logic resp_hit, resp_evict, init_done;
  logic [WAY_W-1:0] resp_way;
  logic [1:0] resp_mesi, resp_evict_mesi;
  logic [TAG_W-1:0] resp_evict_tag;

  always #5 clk = ~clk;

  l2_tag_lru_engine #(.ASSOC(ASSOC), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_tag(req_tag), .req_mesi(req_mesi),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_mesi(resp_mesi),
    .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
    .resp_evict_mesi(resp_evict_mesi), .init_done(init_done)
  );

  int n_tests = 0, n_fail = 0;

  // Model: per-set tags/states and a recency list, ord[s][0] most recent.
  logic [TAG_W-1:0] m_tag [SETS][ASSOC];
  logic [1:0]       m_mesi[SETS][ASSOC];
  int               ord   [SETS][ASSOC];

  logic       e_hit, e_evict, e_chk_way, e_chk_mesi;
  int         e_way;
  logic [1:0] e_mesi, e_emesi;
  logic [7:0] e_etag;

  logic       o_hit, o_evict;
  int         o_way;
  logic [1:0] o_mesi, o_emesi;
  logic [7:0] o_etag;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < ASSOC; w++) begin
        m_tag[s][w] = '0; m_mesi[s][w] = MESI_I; ord[s][w] = w;
      end
  endfunction

  function automatic void m_touch(int s, int w);
    int p = 0;
    for (int i = 0; i < ASSOC; i++) if (ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
  endfunction

  function automatic void model_step(logic [1:0] op, int s, logic [7:0] tag, logic [1:0] mesi);
    int hw = -1, v = -1;
    for (int w = 0; w < ASSOC; w++)
      if (hw < 0 && m_mesi[s][w] != MESI_I && m_tag[s][w] == tag) hw = w;
    e_hit = 0; e_evict = 0; e_way = 0; e_mesi = MESI_I; e_etag = 0; e_emesi = 0;
    e_chk_way = 0; e_chk_mesi = 0;
    case (op)
      OP_LOOKUP: begin
        e_chk_way = 1; e_chk_mesi = 1;
        if (hw >= 0) begin
          e_hit = 1; e_way = hw; e_mesi = m_mesi[s][hw]; m_touch(s, hw);
        end
      end
      OP_FILL: if (mesi != MESI_I) begin
        e_chk_way = 1;
        if (hw >= 0) begin
          e_hit = 1; e_way = hw; e_mesi = m_mesi[s][hw]; e_chk_mesi = 1;
          m_mesi[s][hw] = mesi; m_touch(s, hw);
        end else begin
          for (int w = 0; w < ASSOC; w++) if (v < 0 && m_mesi[s][w] == MESI_I) v = w;
          if (v < 0) v = ord[s][ASSOC-1];
          if (m_mesi[s][v] != MESI_I) begin
            e_evict = 1; e_etag = m_tag[s][v]; e_emesi = m_mesi[s][v];
          end
          m_tag[s][v] = tag; m_mesi[s][v] = mesi; m_touch(s, v); e_way = v;
        end
      end
      OP_SNOOP: if (hw >= 0) begin
        e_hit = 1; e_way = hw; e_mesi = m_mesi[s][hw]; e_chk_way = 1; e_chk_mesi = 1;
        m_mesi[s][hw] = mesi;
      end
      default: ;
    endcase
  endfunction

  task automatic check_resp(input string n);
    check_eq({n, "_valid"}, resp_valid, 1);
    check_eq({n, "_hit"}, resp_hit, e_hit);
    check_eq({n, "_evict"}, resp_evict, e_evict);
    if (e_chk_way) check_eq({n, "_way"}, resp_way, e_way);
    if (e_chk_mesi) check_eq({n, "_mesi"}, resp_mesi, e_mesi);
    if (e_evict) begin
      check_eq({n, "_etag"}, resp_evict_tag, e_etag);
      check_eq({n, "_emesi"}, resp_evict_mesi, e_emesi);
    end
    check_eq({n, "_req_ready"}, req_ready, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the response handshake.
  task automatic do_req(input string n, input logic [1:0] op, input int s, input logic [7:0] tag,
                        input logic [1:0] mesi, input int hold);
    int cnt;
    model_step(op, s, tag, mesi);
    req_op = op; req_index = INDEX_W'(s); req_tag = tag; req_mesi = mesi; req_valid = 1'b1;
    resp_ready = (hold == 0);
    cnt = 0;
    while (!req_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!req_ready) begin
      check_eq({n, "_accept"}, req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_tag = 8'($urandom); req_op = 2'($urandom); req_mesi = 2'($urandom);
    cnt = 0;
    while (!resp_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check_eq({n, "_latency"}, cnt, 2);
    o_hit = resp_hit; o_way = resp_way; o_mesi = resp_mesi;
    o_evict = resp_evict; o_etag = resp_evict_tag; o_emesi = resp_evict_mesi;
    check_resp(n);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_resp({n, "_hold"});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({n, "_pulse"}, resp_valid, 0);
  endtask

  task automatic wait_init(input string n);
    int cnt = 0;
    logic saw_rdy = 0, saw_resp = 0;
    while (!init_done && cnt < 100) begin
      if (req_ready) saw_rdy = 1;
      if (resp_valid) saw_resp = 1;
      @(posedge clk); #1; cnt++;
    end
    check_eq({n, "_cycles"}, cnt, SETS);
    check_eq({n, "_rdy_during"}, saw_rdy, 0);
    check_eq({n, "_resp_during"}, saw_resp, 0);
    check_eq({n, "_rdy_after"}, req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_evict", resp_evict, 0);
    rst_n = 1'b1;
    wait_init("init");

    do_req("lk_empty", OP_LOOKUP, 3, 8'h55, MESI_I, 0);
    check_eq("lk_empty_hit", o_hit, 0);
    check_eq("lk_empty_mesi", o_mesi, MESI_I);

    for (int i = 0; i < 4; i++) begin
      do_req("fill5", OP_FILL, 5, 8'(8'hA0 + i), MESI_E, 0);
      check_eq("fill5_way", o_way, i);
      check_eq("fill5_evict", o_evict, 0);
    end
    do_req("lk_a0", OP_LOOKUP, 5, 8'hA0, MESI_I, 0);
    check_eq("lk_a0_way", o_way, 0);
    check_eq("lk_a0_mesi", o_mesi, MESI_E);
    do_req("fill_b0", OP_FILL, 5, 8'hB0, MESI_S, 0);
    check_eq("fill_b0_way", o_way, 1);
    check_eq("fill_b0_etag", o_etag, 8'hA1);
    check_eq("fill_b0_emesi", o_emesi, MESI_E);

    do_req("fill_c0", OP_FILL, 7, 8'hC0, MESI_M, 0);
    for (int i = 1; i < 4; i++) do_req("fill_c", OP_FILL, 7, 8'(8'hC0 + i), MESI_E, 0);
    do_req("fill_c4", OP_FILL, 7, 8'hC4, MESI_E, 0);
    check_eq("fill_c4_evict", o_evict, 1);
    check_eq("fill_c4_etag", o_etag, 8'hC0);
    check_eq("fill_c4_emesi", o_emesi, MESI_M);

    do_req("snp_a2", OP_SNOOP, 5, 8'hA2, MESI_I, 0);
    check_eq("snp_a2_hit", o_hit, 1);
    check_eq("snp_a2_mesi", o_mesi, MESI_E);
    do_req("fill_d0", OP_FILL, 5, 8'hD0, MESI_E, 0);
    check_eq("fill_d0_way", o_way, 2);
    check_eq("fill_d0_evict", o_evict, 0);

    do_req("fill_i", OP_FILL, 5, 8'hE0, MESI_I, 0);
    do_req("rsvd", OP_RSVD, 5, 8'hA0, MESI_M, 0);
    do_req("hold5", OP_LOOKUP, 5, 8'hB0, MESI_I, 5);

    // Reset while the request sits in READ: no response, full re-init.
    req_op = OP_FILL; req_index = 4'd9; req_tag = 8'h99; req_mesi = MESI_M; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_resp_valid", resp_valid, 0);
    check_eq("midrst_init_done", init_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("reinit");
    model_reset();
    do_req("post_rst_lk", OP_LOOKUP, 5, 8'hA0, MESI_I, 0);
    check_eq("post_rst_hit", o_hit, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? OP_LOOKUP : (r < 7) ? OP_FILL : (r < 9) ? OP_SNOOP : OP_RSVD;
      do_req("rnd", op, $urandom_range(0, 3), 8'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
